input_line_buffer_ctrl: RTL and testbench

- Responder side of the conv row-streaming command interface. Accepts Stream_first_row, Stream_mid_row and Stream_last_row pulses.
- Pulls image rows from an AXI-Stream slave into three rotating line buffers.
- Emits 3-high pixel columns (top/mid/bot) to the PE array.
- Reports Done_1row and Input_line_buffer_IDLE back to the conv control unit. Vertical zero-padding is applied here; horizontal padding is the PE's job.

---
 rtl/conv_pkg.sv | 47 ++++
 rtl/line_buffer_bank.sv | 36 +++
 rtl/input_line_buffer_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_input_line_buffer_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv row-streaming path: line-buffer FSM states,
// default geometry and the IMAGE_SIZE code table used by the control unit.
package conv_pkg;

    localparam int unsigned CONV_DATA_W  = 16;
    localparam int unsigned CONV_MAX_IMG = 128;
    localparam int unsigned CONV_ADDR_W  = 7;
    localparam int unsigned LB_SLOTS     = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_PASS_FIRST,
        S_PASS,
        S_LAST,
        S_DONE
    } lb_state_t;

    typedef enum logic [2:0] {
        IMG_SZ_4,
        IMG_SZ_8,
        IMG_SZ_16,
        IMG_SZ_32,
        IMG_SZ_64,
        IMG_SZ_128
    } img_size_code_t;

    function automatic logic [7:0] img_size_of(input img_size_code_t code);
        logic [7:0] w;
        w = '0;
        if (code <= IMG_SZ_128) begin
            w = 8'd4 << code;
        end
        return w;
    endfunction

    // Rotating slot arithmetic modulo the three line buffers.
    function automatic logic [1:0] slot_add(input logic [1:0] s, input logic [1:0] n);
        logic [2:0] t;
        t = {1'b0, s} + {1'b0, n};
        if (t >= 3'd3) begin
            t = t - 3'd3;
        end
        return t[1:0];
    endfunction

endpackage

// File: rtl/line_buffer_bank.sv
// Three independent simple dual-port line RAMs; one write slot per cycle and
// per-slot read enables with a registered (1-cycle) read.
module line_buffer_bank
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W  = CONV_DATA_W,
    parameter int unsigned MAX_IMG = CONV_MAX_IMG,
    parameter int unsigned ADDR_W  = CONV_ADDR_W
) (
    input  logic                             clk,
    input  logic                             wr_en,
    input  logic [1:0]                       wr_slot,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    input  logic [LB_SLOTS-1:0]              rd_en,
    input  logic [ADDR_W-1:0]                rd_addr,
    output logic [LB_SLOTS-1:0][DATA_W-1:0]  rd_data
);

    for (genvar s = 0; s < LB_SLOTS; s++) begin : g_slot
        logic [DATA_W-1:0] mem [MAX_IMG];
        logic [DATA_W-1:0] q;

        always_ff @(posedge clk) begin
            if (wr_en && (wr_slot == 2'(s))) begin
                mem[wr_addr] <= wr_data;
            end
            if (rd_en[s]) begin
                q <= mem[rd_addr];
            end
        end

        assign rd_data[s] = q;
    end

endmodule

// File: rtl/input_line_buffer_ctrl.sv
// Row-streaming responder: fills three rotating line buffers from AXI-Stream
// and emits vertically zero-padded 3-high pixel columns to the PE array.
module input_line_buffer_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W  = CONV_DATA_W,
    parameter int unsigned MAX_IMG = CONV_MAX_IMG,
    parameter int unsigned ADDR_W  = CONV_ADDR_W
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              Input_line_buffer_Reset,
    input  logic              Stream_first_row,
    input  logic              Stream_mid_row,
    input  logic              Stream_last_row,
    input  logic [7:0]        IMAGE_SIZE,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    input  logic              win_ready,
    output logic [DATA_W-1:0] win_top,
    output logic [DATA_W-1:0] win_mid,
    output logic [DATA_W-1:0] win_bot,
    output logic              win_valid,
    output logic              Done_1row,
    output logic              Input_line_buffer_IDLE,
    output logic              row_err
);

    lb_state_t         state;
    logic [7:0]        img_w;
    logic [ADDR_W-1:0] col;
    logic [1:0]        rot;
    logic              v_q;
    logic              pad_top_q;
    logic              pad_bot_q;
    logic [1:0]        top_slot_q;
    logic [1:0]        mid_slot_q;
    logic [DATA_W-1:0] bot_q;
    logic              err_q;

    logic              in_pass;
    logic              beat;
    logic              last_col;
    logic              rd_issue;
    logic [1:0]        wr_slot;
    logic [LB_SLOTS-1:0] rd_en;
    logic [LB_SLOTS-1:0][DATA_W-1:0] rd_data;

    // The first row pair lands in slots rot and rot+1, so PASS_FIRST writes
    // rot+1 and leaves rot alone; steady-state PASS writes the free slot rot+2.
    always_comb begin
        in_pass       = (state == S_PASS_FIRST) || (state == S_PASS);
        s_axis_tready = (state == S_FILL) || (in_pass && win_ready);
        beat          = s_axis_tvalid && s_axis_tready;
        last_col      = (8'(col) == (img_w - 8'd1));
        rd_issue      = (in_pass && beat) || ((state == S_LAST) && win_ready);
        wr_slot       = rot;
        if (state == S_PASS_FIRST) begin
            wr_slot = slot_add(rot, 2'd1);
        end else if (state == S_PASS) begin
            wr_slot = slot_add(rot, 2'd2);
        end
        rd_en = '0;
        if (rd_issue) begin
            rd_en = LB_SLOTS'(1) << rot;
            if (state != S_PASS_FIRST) begin
                rd_en = rd_en | (LB_SLOTS'(1) << slot_add(rot, 2'd1));
            end
        end
    end

    line_buffer_bank #(
        .DATA_W (DATA_W),
        .MAX_IMG(MAX_IMG),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk    (clk),
        .wr_en  (beat),
        .wr_slot(wr_slot),
        .wr_addr(col),
        .wr_data(s_axis_tdata),
        .rd_en  (rd_en),
        .rd_addr(col),
        .rd_data(rd_data)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= S_IDLE;
            img_w      <= '0;
            col        <= '0;
            rot        <= '0;
            v_q        <= 1'b0;
            pad_top_q  <= 1'b0;
            pad_bot_q  <= 1'b0;
            top_slot_q <= '0;
            mid_slot_q <= '0;
            bot_q      <= '0;
            err_q      <= 1'b0;
        end else if (!Input_line_buffer_Reset) begin
            state      <= S_IDLE;
            img_w      <= '0;
            col        <= '0;
            rot        <= '0;
            v_q        <= 1'b0;
            pad_top_q  <= 1'b0;
            pad_bot_q  <= 1'b0;
            top_slot_q <= '0;
            mid_slot_q <= '0;
            bot_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            v_q <= 1'b0;
            if (beat && (s_axis_tlast != last_col)) begin
                err_q <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (Stream_first_row || Stream_mid_row || Stream_last_row) begin
                        img_w <= IMAGE_SIZE;
                        col   <= '0;
                        if (Stream_first_row) begin
                            rot   <= '0;
                            state <= S_FILL;
                        end else if (Stream_mid_row) begin
                            state <= S_PASS;
                        end else begin
                            state <= S_LAST;
                        end
                    end
                end
                S_FILL: begin
                    if (beat) begin
                        if (last_col) begin
                            col   <= '0;
                            state <= S_PASS_FIRST;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_PASS_FIRST, S_PASS: begin
                    if (beat) begin
                        v_q        <= 1'b1;
                        bot_q      <= s_axis_tdata;
                        pad_top_q  <= (state == S_PASS_FIRST);
                        pad_bot_q  <= 1'b0;
                        top_slot_q <= rot;
                        mid_slot_q <= (state == S_PASS_FIRST) ? rot : slot_add(rot, 2'd1);
                        if (last_col) begin
                            col   <= '0;
                            state <= S_DONE;
                            if (state == S_PASS) begin
                                rot <= slot_add(rot, 2'd1);
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_LAST: begin
                    if (win_ready) begin
                        v_q        <= 1'b1;
                        pad_top_q  <= 1'b0;
                        pad_bot_q  <= 1'b1;
                        top_slot_q <= rot;
                        mid_slot_q <= slot_add(rot, 2'd1);
                        if (last_col) begin
                            col   <= '0;
                            state <= S_DONE;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign win_valid              = v_q;
    assign win_top                = (v_q && !pad_top_q) ? rd_data[top_slot_q] : '0;
    assign win_mid                = v_q ? rd_data[mid_slot_q] : '0;
    assign win_bot                = (v_q && !pad_bot_q) ? bot_q : '0;
    assign Done_1row              = (state == S_DONE);
    assign Input_line_buffer_IDLE = (state == S_IDLE);
    assign row_err                = err_q;

endmodule

// File: tb/tb_input_line_buffer_ctrl.sv
// Scoreboard bench for input_line_buffer_ctrl: expected columns are derived
// from a two-row history model and compared as win_valid beats appear.
module tb_input_line_buffer_ctrl;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          Input_line_buffer_Reset;
    logic          Stream_first_row;
    logic          Stream_mid_row;
    logic          Stream_last_row;
    logic [7:0]    IMAGE_SIZE;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic          win_ready;
    logic [DW-1:0] win_top;
    logic [DW-1:0] win_mid;
    logic [DW-1:0] win_bot;
    logic          win_valid;
    logic          Done_1row;
    logic          Input_line_buffer_IDLE;
    logic          row_err;

    always #5 clk = ~clk;

    input_line_buffer_ctrl #(
        .DATA_W (DW),
        .MAX_IMG(128),
        .ADDR_W (7)
    ) dut (
        .clk                   (clk),
        .aresetn               (aresetn),
        .Input_line_buffer_Reset(Input_line_buffer_Reset),
        .Stream_first_row      (Stream_first_row),
        .Stream_mid_row        (Stream_mid_row),
        .Stream_last_row       (Stream_last_row),
        .IMAGE_SIZE            (IMAGE_SIZE),
        .s_axis_tdata          (s_axis_tdata),
        .s_axis_tvalid         (s_axis_tvalid),
        .s_axis_tlast          (s_axis_tlast),
        .s_axis_tready         (s_axis_tready),
        .win_ready             (win_ready),
        .win_top               (win_top),
        .win_mid               (win_mid),
        .win_bot               (win_bot),
        .win_valid             (win_valid),
        .Done_1row             (Done_1row),
        .Input_line_buffer_IDLE(Input_line_buffer_IDLE),
        .row_err               (row_err)
    );

    typedef struct packed {
        logic [DW-1:0] t;
        logic [DW-1:0] m;
        logic [DW-1:0] b;
        logic          d;
    } win_t;

    win_t          sb[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            win_cnt  = 0;
    int            done_cnt = 0;
    logic [DW-1:0] pix   [8][128];
    logic [DW-1:0] m_old [128];
    logic [DW-1:0] m_new [128];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Each window column pops the next expectation; Done must ride the last one.
    initial begin : monitor
        win_t e;
        forever begin
            @(negedge clk);
            if (win_valid) begin
                win_cnt++;
                if (sb.size() == 0) begin
                    chk("spurious_win", 32'(win_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("win_top", 32'(win_top), 32'(e.t));
                    chk("win_mid", 32'(win_mid), 32'(e.m));
                    chk("win_bot", 32'(win_bot), 32'(e.b));
                    chk("done_align", 32'(Done_1row), 32'(e.d));
                end
            end else if (Done_1row) begin
                chk("done_without_win", 32'(Done_1row), 32'd0);
            end
            if (Done_1row) begin
                done_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic exp_first(input int w, input int ra, input int rb);
        win_t e;
        for (int j = 0; j < w; j++) begin
            e.t = '0;
            e.m = pix[ra][j];
            e.b = pix[rb][j];
            e.d = (j == w - 1);
            sb.push_back(e);
            m_old[j] = pix[ra][j];
            m_new[j] = pix[rb][j];
        end
    endtask

    task automatic exp_mid(input int w, input int r);
        win_t e;
        for (int j = 0; j < w; j++) begin
            e.t = m_old[j];
            e.m = m_new[j];
            e.b = pix[r][j];
            e.d = (j == w - 1);
            sb.push_back(e);
            m_old[j] = m_new[j];
            m_new[j] = pix[r][j];
        end
    endtask

    task automatic exp_last(input int w);
        win_t e;
        for (int j = 0; j < w; j++) begin
            e.t = m_old[j];
            e.m = m_new[j];
            e.b = '0;
            e.d = (j == w - 1);
            sb.push_back(e);
        end
    endtask

    // All driver tasks start and end at posedge + 1.
    task automatic cmd(input logic f, input logic m, input logic l, input logic [7:0] w);
        IMAGE_SIZE       = w;
        Stream_first_row = f;
        Stream_mid_row   = m;
        Stream_last_row  = l;
        @(posedge clk);
        #1;
        Stream_first_row = 1'b0;
        Stream_mid_row   = 1'b0;
        Stream_last_row  = 1'b0;
        chk("idle_after_cmd", 32'(Input_line_buffer_IDLE), 32'd0);
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        bit ok;
        ok            = 1'b0;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (s_axis_tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("beat_timeout", 32'(s_axis_tready), 32'd1);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_row(input int w, input int r, input int tl_col, input int stall_col,
                            input int busy_col, input int nbeats);
        for (int j = 0; j < nbeats; j++) begin
            if (j == stall_col) begin
                win_ready     = 1'b0;
                s_axis_tdata  = pix[r][j];
                s_axis_tvalid = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("stall_tready", 32'(s_axis_tready), 32'd0);
                    if (i > 0) begin
                        chk("stall_no_win", 32'(win_valid), 32'd0);
                    end
                end
                @(posedge clk);
                #1;
                win_ready = 1'b1;
            end
            if (j == busy_col) begin
                Stream_first_row = 1'b1;
            end
            send_beat(pix[r][j], (j == tl_col));
            Stream_first_row = 1'b0;
        end
        if (w < nbeats) begin
            chk("row_len", 32'(nbeats), 32'(w));
        end
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (Input_line_buffer_IDLE) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic finish_row(input string tag, input int d0);
        wait_idle(tag);
        chk("done_per_row", 32'(done_cnt - d0), 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin : main
        int d0;
        int w0;
        aresetn                 = 1'b0;
        Input_line_buffer_Reset = 1'b1;
        Stream_first_row        = 1'b0;
        Stream_mid_row          = 1'b0;
        Stream_last_row         = 1'b0;
        IMAGE_SIZE              = 8'd4;
        s_axis_tdata            = '0;
        s_axis_tvalid           = 1'b0;
        s_axis_tlast            = 1'b0;
        win_ready               = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                pix[r][j] = DW'(r * 4 + j + 1);
            end
        end
        for (int r = 4; r < 8; r++) begin
            for (int j = 0; j < 128; j++) begin
                pix[r][j] = DW'($urandom);
            end
        end

        #12;
        chk("rst_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_win_valid", 32'(win_valid), 32'd0);
        chk("rst_win_top", 32'(win_top), 32'd0);
        chk("rst_win_bot", 32'(win_bot), 32'd0);
        chk("rst_done", 32'(Done_1row), 32'd0);
        chk("rst_row_err", 32'(row_err), 32'd0);
        chk("rst_idle", 32'(Input_line_buffer_IDLE), 32'd1);
        @(posedge clk);
        #1;
        aresetn = 1'b1;

        // 4x4 image: first, mid (with stall at col 2), mid+last together, last
        exp_first(4, 0, 1);
        d0 = done_cnt;
        cmd(1'b1, 1'b0, 1'b0, 8'd4);
        send_row(4, 0, 3, -1, -1, 4);
        send_row(4, 1, 3, -1, -1, 4);
        finish_row("idle_first", d0);

        exp_mid(4, 2);
        d0 = done_cnt;
        cmd(1'b0, 1'b1, 1'b0, 8'd4);
        send_row(4, 2, 3, 2, -1, 4);
        finish_row("idle_mid_stall", d0);

        exp_mid(4, 3);
        d0 = done_cnt;
        cmd(1'b0, 1'b1, 1'b1, 8'd4);
        chk("mid_priority_tready", 32'(s_axis_tready), 32'd1);
        send_row(4, 3, 3, -1, 1, 4);
        finish_row("idle_mid_prio", d0);

        exp_last(4);
        d0 = done_cnt;
        cmd(1'b0, 1'b0, 1'b1, 8'd4);
        chk("last_tready", 32'(s_axis_tready), 32'd0);
        finish_row("idle_last", d0);
        chk("row_err_clean", 32'(row_err), 32'd0);

        // early tlast on a 4-wide row
        exp_first(4, 4, 5);
        d0 = done_cnt;
        cmd(1'b1, 1'b0, 1'b0, 8'd4);
        send_row(4, 4, 1, -1, -1, 4);
        chk("row_err_set", 32'(row_err), 32'd1);
        send_row(4, 5, 3, -1, -1, 4);
        finish_row("idle_tlast", d0);
        chk("row_err_sticky", 32'(row_err), 32'd1);

        // full-width 128 row
        exp_first(128, 6, 7);
        d0 = done_cnt;
        w0 = win_cnt;
        cmd(1'b1, 1'b0, 1'b0, 8'd128);
        send_row(128, 6, 127, -1, -1, 128);
        send_row(128, 7, 127, -1, -1, 128);
        finish_row("idle_128", d0);
        chk("win_count_128", 32'(win_cnt - w0), 32'd128);
        chk("row_err_sticky_128", 32'(row_err), 32'd1);

        // asynchronous reset in the middle of a mid row
        exp_mid(4, 2);
        cmd(1'b0, 1'b1, 1'b0, 8'd4);
        send_row(4, 2, 3, -1, -1, 2);
        @(negedge clk);
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst_tready", 32'(s_axis_tready), 32'd0);
        chk("arst_win_valid", 32'(win_valid), 32'd0);
        chk("arst_win_top", 32'(win_top), 32'd0);
        chk("arst_win_mid", 32'(win_mid), 32'd0);
        chk("arst_win_bot", 32'(win_bot), 32'd0);
        chk("arst_done", 32'(Done_1row), 32'd0);
        chk("arst_row_err", 32'(row_err), 32'd0);
        chk("arst_idle", 32'(Input_line_buffer_IDLE), 32'd1);
        sb.delete();
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;
        chk("arst_no_done", 32'(done_cnt - d0), 32'd0);

        // recovery after reset
        exp_first(4, 0, 1);
        d0 = done_cnt;
        cmd(1'b1, 1'b0, 1'b0, 8'd4);
        send_row(4, 0, 3, -1, -1, 4);
        send_row(4, 1, 3, -1, -1, 4);
        finish_row("idle_recover", d0);

        // synchronous soft reset while filling
        cmd(1'b1, 1'b0, 1'b0, 8'd4);
        send_row(4, 4, 3, -1, -1, 2);
        Input_line_buffer_Reset = 1'b0;
        @(posedge clk);
        #1;
        Input_line_buffer_Reset = 1'b1;
        chk("srst_idle", 32'(Input_line_buffer_IDLE), 32'd1);
        chk("srst_tready", 32'(s_axis_tready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("srst_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
